nios2_sysid_arbiter: RTL and testbench
======================================

# nios2_sysid_arbiter

Shares the single system-ID slave (word 0 = system ID, word 1 = build timestamp, combinational read, 1-bit address) between two Avalon-MM read masters. After every reset it runs a self-check that reads both words and compares them against expected parameters. It sits in the NIOS2 system between the CPU data master, the debug/host master and the sysid control slave. It adds a registered, fixed-latency, pipelined read path with round-robin arbitration.

## Interface
- EXPECTED_ID, 32'd1, value word 0 must return
- EXPECTED_TIMESTAMP, 32'd1501838636, value word 1 must return
- clock  in  1  single system clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- m0_read  in  1  master 0 read request
- m0_address  in  1  master 0 word address
- m0_waitrequest  out  1  master 0 stall
- m0_readdatavalid  out  1  master 0 response strobe
- m0_readdata  out  32  master 0 response data
- m1_read, m1_address, m1_waitrequest, m1_readdatavalid, m1_readdata: same as m0 for master 1
- sid_address  out  1  address to sysid slave
- sid_readdata  in  32  sysid slave read data (combinational on sid_address)
- check_done  out  1  self-check finished
- id_ok  out  1  both words matched expected values
- id_bad  out  1  at least one word mismatched

## Operation
- Checker FSM: CHK_ID -> CHK_TS -> WAIT -> DONE. Reset enters CHK_ID.
  - CHK_ID issues an internal read of address 0. CHK_TS issues address 1.
  - WAIT holds until both responses have returned, then moves to DONE.
  - DONE is terminal until the next reset.
- The checker owns the slave until DONE. While the FSM is not in DONE, any asserted mN_read sees mN_waitrequest=1.
- In DONE, round-robin arbitration applies:
  - A single requester is granted.
  - If both request, grant the master not granted last. last_grant resets to m1, so m0 wins the first tie.
- Waitrequest is combinational: mN_waitrequest = mN_read & ~grantN. The granted master sees waitrequest=0, and the read is accepted that cycle.
- Pipeline stage 1, on accept: register sid_address <= granted address and tag <= source (m0/m1/checker). Assert valid1.
- Pipeline stage 2: capture sid_readdata into resp_data and the tag into resp_tag. Assert resp_valid.
- mN_readdatavalid = resp_valid & (resp_tag==N). Both mN_readdata are driven from resp_data.
- Checker responses never raise either master's readdatavalid.
- Comparison:
  - Word 0 compares against EXPECTED_ID and word 1 against EXPECTED_TIMESTAMP, 32-bit exact equality.
  - Results latch in sticky flags.
  - On entering DONE: check_done=1, id_ok = both equal, id_bad = ~id_ok. These hold until reset.
- A request dropped while stalled is not recorded and gets no response.
- The address is sampled only in the accept cycle.

## Timing
- Reset values: sid_address=0, m0/m1_readdatavalid=0, m0/m1_readdata=0, check_done=0, id_ok=0, id_bad=0.
  - During reset, waitrequest=1 for any asserted read.
  - In-flight pipeline entries are discarded.
- Fixed read latency 2:
  - Accept at edge T (waitrequest=0 sampled).
  - sid_address valid after T+1.
  - mN_readdatavalid=1 and data valid for exactly cycle T+2.
- Throughput is one accepted read per cycle across both masters. A continuously requesting single master gets back-to-back responses.
- Under continuous contention, grants alternate m0, m1, m0, ...
- Self-check timing:
  - CHK_ID read accepted in cycle 0 after reset deassert.
  - CHK_TS read accepted in cycle 1.
  - Responses return in cycles 2 and 3.
  - check_done, id_ok and id_bad are valid from cycle 4.
  - A master's first grant is possible in cycle 4.
- Reset asserted mid-operation:
  - Pending responses are not delivered and flags clear.
  - The checker restarts, and masters stall until the new DONE.

## Test plan
- Reset, matching slave (word0=1, word1=1501838636), no master traffic -> check_done=1 and id_ok=1 and id_bad=0 in cycle 4, and no mN_readdatavalid pulse at any time.
- Slave word1 forced to 0 -> check_done=1, id_ok=0, id_bad=1 in cycle 4, sticky for 100 cycles.
- m0_read held from cycle 0 with address 1 -> m0_waitrequest=1 cycles 0-3, accepted cycle 4, m0_readdatavalid in cycle 6 with readdata=1501838636.
- After DONE, m0 and m1 request continuously (m0 addr0, m1 addr1) for 6 cycles -> grants m0,m1,m0,m1,m0,m1. Responses alternate 1/1501838636, each 2 cycles after its accept, with no gaps.
- m1 accepted in cycle T, then reset asserted in cycle T+1 -> no m1_readdatavalid at T+2, and all outputs return to reset values.
- m0 asserts read during the checker stall, then deasserts before cycle 4 -> no grant and no response, and the checker result is unaffected.

Source files
------------

// File: rtl/nios2_sysid_arbiter.sv
// Two-master round-robin front end for the sysid slave with a fixed 2-cycle registered read path.
// After reset a checker reads both sysid words and reports whether they match the expected values.
module nios2_sysid_arbiter #(
  parameter logic [31:0] EXPECTED_ID        = 32'd1,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1501838636
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic        m0_readdatavalid,
  output logic [31:0] m0_readdata,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic        m1_readdatavalid,
  output logic [31:0] m1_readdata,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        check_done,
  output logic        id_ok,
  output logic        id_bad
);

  typedef enum logic [1:0] {StChkId, StChkTs, StWait, StDone} state_e;

  localparam logic [1:0] TagM0  = 2'd0;
  localparam logic [1:0] TagM1  = 2'd1;
  localparam logic [1:0] TagChk = 2'd2;

  state_e      state_q, state_d;
  logic        chk_issue, chk_addr, done;
  logic        grant0, grant1, accept, accept_addr;
  logic [1:0]  accept_tag;
  logic        last_grant_q;  // 1: m1 was granted last
  logic        valid1_q;
  logic [1:0]  tag1_q;
  logic        resp_valid_q, resp_addr_q;
  logic [1:0]  resp_tag_q;
  logic [31:0] resp_data_q;
  logic        chk_rsp, chk_cnt_q, id_match_q, ts_match_q;

  assign chk_rsp = resp_valid_q & (resp_tag_q == TagChk);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StChkId;
    else       state_q <= state_d;
  end

  // FSM next state; the second checker response closes the wait
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StChkId: state_d = StChkTs;
      StChkTs: state_d = StWait;
      StWait:  if (chk_rsp && chk_cnt_q) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StChkId;
    endcase
  end

  // FSM outputs
  always_comb begin
    chk_issue = 1'b0;
    chk_addr  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StChkId: chk_issue = 1'b1;
      StChkTs: begin
        chk_issue = 1'b1;
        chk_addr  = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Masters only see grants once the checker has released the slave
  always_comb begin
    grant0      = done & ~reset & m0_read & (~m1_read | last_grant_q);
    grant1      = done & ~reset & m1_read & (~m0_read | ~last_grant_q);
    accept      = (chk_issue & ~reset) | grant0 | grant1;
    accept_addr = chk_issue ? chk_addr : (grant1 ? m1_address : m0_address);
    accept_tag  = chk_issue ? TagChk : (grant1 ? TagM1 : TagM0);
  end

  assign m0_waitrequest = m0_read & ~grant0;
  assign m1_waitrequest = m1_read & ~grant1;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      valid1_q     <= 1'b0;
      tag1_q       <= TagM0;
      sid_address  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= TagM0;
      resp_addr_q  <= 1'b0;
      resp_data_q  <= '0;
      chk_cnt_q    <= 1'b0;
      id_match_q   <= 1'b0;
      ts_match_q   <= 1'b0;
    end else begin
      if (grant0 || grant1) last_grant_q <= grant1;
      valid1_q <= accept;
      if (accept) begin
        sid_address <= accept_addr;
        tag1_q      <= accept_tag;
      end
      resp_valid_q <= valid1_q;
      if (valid1_q) begin
        resp_tag_q  <= tag1_q;
        resp_addr_q <= sid_address;
        resp_data_q <= sid_readdata;
      end
      if (chk_rsp) begin
        chk_cnt_q <= 1'b1;
        if (resp_addr_q) ts_match_q <= (resp_data_q == EXPECTED_TIMESTAMP);
        else             id_match_q <= (resp_data_q == EXPECTED_ID);
      end
    end
  end

  assign m0_readdatavalid = resp_valid_q & (resp_tag_q == TagM0);
  assign m1_readdatavalid = resp_valid_q & (resp_tag_q == TagM1);
  assign m0_readdata      = resp_data_q;
  assign m1_readdata      = resp_data_q;

  assign check_done = done;
  assign id_ok      = done & id_match_q & ts_match_q;
  assign id_bad     = done & ~(id_match_q & ts_match_q);

endmodule

// File: tb/tb_nios2_sysid_arbiter.sv
// Directed bench for nios2_sysid_arbiter: a per-cycle vector table plus reset/stall/mismatch sequences.
module tb_nios2_sysid_arbiter;

  localparam logic [31:0] ID = 32'd1;
  localparam logic [31:0] TS = 32'd1501838636;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_read, m0_address, m0_waitrequest, m0_readdatavalid;
  logic        m1_read, m1_address, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, sid_readdata;
  logic        sid_address, check_done, id_ok, id_bad;
  logic [31:0] word0 = ID;
  logic [31:0] word1 = TS;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign sid_readdata = sid_address ? word1 : word0;

  nios2_sysid_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .m0_read          (m0_read),
    .m0_address       (m0_address),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_readdata      (m0_readdata),
    .m1_read          (m1_read),
    .m1_address       (m1_address),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_readdata      (m1_readdata),
    .sid_address      (sid_address),
    .sid_readdata     (sid_readdata),
    .check_done       (check_done),
    .id_ok            (id_ok),
    .id_bad           (id_bad)
  );

  // Fields: m0 read/addr, m1 read/addr, exp waitrequest 0/1, exp readdatavalid 0/1,
  // data is TS (else ID), exp check_done/id_ok, sid_address checked/expected
  typedef struct packed {
    logic m0r, m0a, m1r, m1a;
    logic w0, w1, v0, v1;
    logic dts;
    logic done, ok;
    logic sidc, sid;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    m0_read    = 1'b0;
    m0_address = 1'b0;
    m1_read    = 1'b0;
    m1_address = 1'b0;
    next_cycle();
    @(negedge clock);
    chk("rst sid_address", {31'd0, sid_address}, 32'd0);
    chk("rst m0_readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
    chk("rst m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
    chk("rst m0_readdata", m0_readdata, 32'd0);
    chk("rst m1_readdata", m1_readdata, 32'd0);
    chk("rst flags", {29'd0, check_done, id_ok, id_bad}, 32'd0);
    next_cycle();
    reset = 1'b0;
  endtask

  // From cycle 0: m0 reads address 0 for the first stall_n cycles; no response may ever appear
  task automatic run_watch(input int n, input int stall_n, input logic exp_ok, input string tag);
    for (int c = 0; c < n; c++) begin
      m0_read    = (c < stall_n);
      m0_address = 1'b0;
      @(negedge clock);
      if (c < stall_n) chk($sformatf("%s c%0d m0_waitrequest", tag, c), {31'd0, m0_waitrequest}, 32'd1);
      chk($sformatf("%s c%0d readdatavalid", tag, c),
          {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      chk($sformatf("%s c%0d done/ok/bad", tag, c), {29'd0, check_done, id_ok, id_bad},
          {29'd0, c >= 4, (c >= 4) & exp_ok, (c >= 4) & ~exp_ok});
      next_cycle();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl = '{
      13'b11_00_10_00_0_00_10,  // c0  checker reads ID, m0 stalled
      13'b11_00_10_00_0_00_10,
      13'b11_00_10_00_0_00_11,
      13'b11_00_10_00_0_00_00,
      13'b11_00_00_00_0_11_00,  // c4  DONE, m0 addr1 accepted
      13'b00_11_00_00_0_11_11,  // c5  m1 alone accepted
      13'b10_11_01_10_1_11_11,  // c6  contention starts, m0 wins
      13'b10_11_10_01_1_11_10,
      13'b10_11_01_10_0_11_11,
      13'b10_11_10_01_1_11_10,
      13'b10_11_01_10_0_11_11,
      13'b10_11_10_01_1_11_10,
      13'b00_00_00_10_0_11_11,
      13'b00_00_00_01_1_11_00,
      13'b00_00_00_00_0_11_00,
      13'b00_00_00_00_0_11_00
    };

    // Matching slave, no master traffic
    do_reset();
    run_watch(12, 0, 1'b1, "idle");

    // Vector table: stalled m0 from cycle 0, then single and contended grants
    do_reset();
    for (int i = 0; i < 16; i++) begin
      m0_read    = tbl[i].m0r;
      m0_address = tbl[i].m0a;
      m1_read    = tbl[i].m1r;
      m1_address = tbl[i].m1a;
      @(negedge clock);
      chk($sformatf("c%0d waitrequest", i), {30'd0, m0_waitrequest, m1_waitrequest},
          {30'd0, tbl[i].w0, tbl[i].w1});
      chk($sformatf("c%0d readdatavalid", i), {30'd0, m0_readdatavalid, m1_readdatavalid},
          {30'd0, tbl[i].v0, tbl[i].v1});
      if (tbl[i].v0) chk($sformatf("c%0d m0_readdata", i), m0_readdata, tbl[i].dts ? TS : ID);
      if (tbl[i].v1) chk($sformatf("c%0d m1_readdata", i), m1_readdata, tbl[i].dts ? TS : ID);
      chk($sformatf("c%0d done/ok/bad", i), {29'd0, check_done, id_ok, id_bad},
          {29'd0, tbl[i].done, tbl[i].ok, tbl[i].done & ~tbl[i].ok});
      if (tbl[i].sidc) chk($sformatf("c%0d sid_address", i), {31'd0, sid_address},
                           {31'd0, tbl[i].sid});
      next_cycle();
    end

    // m1 accepted at T, reset at T+1: response dropped, everything back to reset values
    m1_read    = 1'b1;
    m1_address = 1'b0;
    @(negedge clock);
    chk("midrst accept m1_waitrequest", {31'd0, m1_waitrequest}, 32'd0);
    next_cycle();
    m1_read = 1'b0;
    reset   = 1'b1;
    m0_read = 1'b1;
    @(negedge clock);
    chk("midrst T+1 m0_waitrequest", {31'd0, m0_waitrequest}, 32'd1);
    next_cycle();
    @(negedge clock);
    chk("midrst T+2 readdatavalid", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
    chk("midrst T+2 flags", {29'd0, check_done, id_ok, id_bad}, 32'd0);
    chk("midrst T+2 sid_address", {31'd0, sid_address}, 32'd0);
    chk("midrst T+2 readdata", m1_readdata | m0_readdata, 32'd0);
    chk("midrst T+2 m0_waitrequest", {31'd0, m0_waitrequest}, 32'd1);
    next_cycle();
    reset = 1'b0;

    // m0 requests during the checker stall and drops out before cycle 4
    run_watch(12, 3, 1'b1, "stall");

    // Timestamp word wrong: sticky failure
    word1 = 32'd0;
    do_reset();
    run_watch(104, 0, 1'b0, "bad");
    word1 = TS;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
